// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle add/subtract, DIGIT bits per clock via a registered carry.
// Ports: clk, rst, start/sub/a/b/cin in; busy, done pulse, sum/cout/ovf registered out.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH ||
      (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_add_sub: DIGIT must divide WIDTH, WIDTH >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_c;
  logic             dig_c_msb;
  logic [WIDTH-1:0] res_ins;
  logic [WIDTH-1:0] res_shift;

  // Ripple through the current digit; dig_c_msb is the carry into
  // the digit's top bit, which on the last digit is bit WIDTH-1.
  always_comb begin
    dig_c     = carry_q;
    dig_c_msb = carry_q;
    dig_sum   = '0;
    for (int i = 0; i < DIGIT; i++) begin
      dig_c_msb  = dig_c;
      dig_sum[i] = a_q[i] ^ b_q[i] ^ dig_c;
      dig_c      = (a_q[i] & b_q[i]) | (dig_c & (a_q[i] ^ b_q[i]));
    end
    res_ins                   = '0;
    res_ins[WIDTH-1 -: DIGIT] = dig_sum;
    res_shift                 = (res_q >> DIGIT) | res_ins;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_shift;
        carry_d = dig_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = res_shift;
          cout_d  = dig_c;
          ovf_d   = dig_c_msb ^ dig_c;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub over four WIDTH/DIGIT configurations.
// Expected results are queued at start and popped at each done pulse.
module tb_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start_v;
  logic       sub_in;
  logic       cin_in;
  logic [7:0] a_in;
  logic [7:0] b_in;

  logic [3:0] busy_v;
  logic [3:0] done_v;
  logic [3:0] cout_v;
  logic [3:0] ovf_v;
  logic [7:0] sum_w0, sum_w1, sum_w3;
  logic [3:0] sum_w2;
  wire  [7:0] sum_v [4];

  assign sum_v[0] = sum_w0;
  assign sum_v[1] = sum_w1;
  assign sum_v[2] = {4'h0, sum_w2};
  assign sum_v[3] = sum_w3;

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];

  int wk[4] = '{8, 8, 4, 8};
  int nk[4] = '{8, 2, 4, 1};

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_in),
    .a(a_in), .b(b_in), .cin(cin_in),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_w0),
    .cout(cout_v[0]), .ovf(ovf_v[0])
  );

  serial_add_sub #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_in),
    .a(a_in), .b(b_in), .cin(cin_in),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_w1),
    .cout(cout_v[1]), .ovf(ovf_v[1])
  );

  serial_add_sub #(.WIDTH(4), .DIGIT(1)) u_w4 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_in),
    .a(a_in[3:0]), .b(b_in[3:0]), .cin(cin_in),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_w2),
    .cout(cout_v[2]), .ovf(ovf_v[2])
  );

  serial_add_sub #(.WIDTH(8), .DIGIT(8)) u_df (
    .clk(clk), .rst(rst), .start(start_v[3]), .sub(sub_in),
    .a(a_in), .b(b_in), .cin(cin_in),
    .busy(busy_v[3]), .done(done_v[3]), .sum(sum_w3),
    .cout(cout_v[3]), .ovf(ovf_v[3])
  );

  // {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [9:0] model(input int w, input logic [7:0] av,
                                       input logic [7:0] bv, input logic s,
                                       input logic ci);
    int mask, aa, bb, full, sm;
    logic sa, sb, ss, co, ov;
    mask = (1 << w) - 1;
    aa   = int'(av) & mask;
    bb   = (s ? int'(~bv) : int'(bv)) & mask;
    full = aa + bb + int'(ci ^ s);
    sm   = full & mask;
    co   = ((full >> w) & 1) != 0;
    sa   = ((aa >> (w - 1)) & 1) != 0;
    sb   = ((bb >> (w - 1)) & 1) != 0;
    ss   = ((sm >> (w - 1)) & 1) != 0;
    ov   = (sa == sb) && (ss != sa);
    return {ov, co, sm[7:0]};
  endfunction

  // Drive one start cycle; returns #1 after the accepting edge E0.
  task automatic issue(input int k, input logic [7:0] av,
                       input logic [7:0] bv, input logic s,
                       input logic ci);
    a_in       = av;
    b_in       = bv;
    sub_in     = s;
    cin_in     = ci;
    start_v[k] = 1'b1;
    exp_q.push_back(model(wk[k], av, bv, s, ci));
    @(posedge clk); #1;
    start_v[k] = 1'b0;
  endtask

  // Waits for done (bounded); lat = -1 on timeout. Steps one edge past done.
  task automatic wait_done(input int k, output int lat,
                           output logic [9:0] got, output logic post_done);
    lat       = -1;
    got       = '0;
    post_done = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done_v[k]) begin
        lat = c;
        got = {ovf_v[k], cout_v[k], sum_v[k]};
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      post_done = done_v[k];
    end
  endtask

  task automatic test_reset();
    logic [14:0] z;
    for (int k = 0; k < 4; k++) begin
      z = {busy_v[k], done_v[k], cout_v[k], ovf_v[k], sum_v[k], 3'b0};
      n_cmp++;
      if (z !== 15'h0) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: got %h want 0", k, z);
      end
    end
  endtask

  task automatic test_add_basic();
    int lat, bcnt;
    logic [9:0] got, exp;
    issue(0, 8'h5A, 8'h3C, 1'b0, 1'b0);
    bcnt = busy_v[0] ? 1 : 0;
    lat  = -1;
    got  = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (busy_v[0]) bcnt++;
      if (done_v[0]) begin
        lat = c;
        got = {ovf_v[0], cout_v[0], sum_v[0]};
        break;
      end
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (lat !== 8) begin
      n_bad++; $display("FAIL add_latency: got %0d want 8", lat);
    end
    n_cmp++;
    if (got !== {1'b1, 1'b0, 8'h96}) begin
      n_bad++; $display("FAIL add_5a_3c: got %h want %h", got, {2'b10, 8'h96});
    end
    n_cmp++;
    if (got !== exp) begin
      n_bad++; $display("FAIL add_5a_3c_model: got %h want %h", got, exp);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({done_v[0], busy_v[0]} !== 2'b00) begin
      n_bad++; $display("FAIL add_after_done: got %b want 00", {done_v[0], busy_v[0]});
    end
    n_cmp++;
    if (bcnt !== 9) begin
      n_bad++; $display("FAIL add_busy_cycles: got %0d want 9", bcnt);
    end
  endtask

  task automatic test_vectors();
    logic [7:0]  ta[4] = '{8'h10, 8'h80, 8'hFF, 8'h7F};
    logic [7:0]  tb_[4] = '{8'h20, 8'h01, 8'h01, 8'h00};
    logic        ts[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        tc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [9:0]  te[4] = '{10'h0F0, 10'h37F, 10'h100, 10'h280};
    int lat;
    logic [9:0] got, exp;
    logic pd;
    for (int i = 0; i < 4; i++) begin
      issue(0, ta[i], tb_[i], ts[i], tc[i]);
      wait_done(0, lat, got, pd);
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== te[i] || lat !== 8) begin
        n_bad++;
        $display("FAIL vector[%0d]: got %h lat %0d want %h lat 8", i, got, lat, te[i]);
      end
      n_cmp++;
      if (got !== exp || pd !== 1'b0) begin
        n_bad++;
        $display("FAIL vector_model[%0d]: got %h pulse2 %b want %h pulse2 0", i, got, pd, exp);
      end
    end
  endtask

  task automatic test_start_ignored();
    int pulses;
    logic [9:0] got, exp;
    issue(0, 8'h11, 8'h22, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_in = 8'hFF; b_in = 8'hFF; sub_in = 1'b1; cin_in = 1'b1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    pulses = 0;
    got = '0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (done_v[0]) begin
        pulses++;
        if (pulses == 1) got = {ovf_v[0], cout_v[0], sum_v[0]};
      end
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++; $display("FAIL ignore_pulses: got %0d want 1", pulses);
    end
    n_cmp++;
    if (got !== exp) begin
      n_bad++; $display("FAIL ignore_result: got %h want %h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2, seen;
    logic [9:0] got, exp;
    a_in = 8'hC3; b_in = 8'h5E; sub_in = 1'b1; cin_in = 1'b1;
    exp_q.push_back(model(8, 8'hC3, 8'h5E, 1'b1, 1'b1));
    exp_q.push_back(model(8, 8'hC3, 8'h5E, 1'b1, 1'b1));
    start_v[1] = 1'b1;
    t1 = -1; t2 = -1; seen = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done_v[1]) begin
        seen++;
        got = {ovf_v[1], cout_v[1], sum_v[1]};
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
          n_bad++; $display("FAIL b2b_result[%0d]: got %h want %h", seen, got, exp);
        end
        if (seen == 1) t1 = c;
        else begin
          t2 = c;
          start_v[1] = 1'b0;
          break;
        end
      end
    end
    start_v[1] = 1'b0;
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    n_cmp++;
    if (t1 !== 3 || t2 !== 7) begin
      n_bad++; $display("FAIL b2b_timing: got %0d,%0d want 3,7", t1, t2);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy_v[1] !== 1'b0) begin
      n_bad++; $display("FAIL b2b_stop: got busy %b want 0", busy_v[1]);
    end
  endtask

  task automatic test_reset_abort();
    int pulses, lat;
    logic [9:0] got, exp;
    logic pd;
    logic [11:0] z;
    issue(0, 8'h5A, 8'h3C, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    z = {busy_v[0], done_v[0], cout_v[0], ovf_v[0], sum_v[0]};
    n_cmp++;
    if (z !== 12'h0) begin
      n_bad++; $display("FAIL abort_outputs: got %h want 0", z);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done_v[0]) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++; $display("FAIL abort_no_done: got %0d want 0", pulses);
    end
    issue(0, 8'h01, 8'h02, 1'b0, 1'b1);
    wait_done(0, lat, got, pd);
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp || lat !== 8) begin
      n_bad++; $display("FAIL abort_restart: got %h lat %0d want %h lat 8", got, lat, exp);
    end
  endtask

  task automatic test_config(input int k, input int reps);
    int lat;
    logic [9:0] got, exp;
    logic pd;
    logic [7:0] av, bv;
    for (int i = 0; i < reps; i++) begin
      av = 8'($urandom_range(0, 255));
      bv = 8'($urandom_range(0, 255));
      if (i == 0) begin av = 8'hFF; bv = 8'h01; end
      if (i == 1) begin av = 8'h80; bv = 8'h7F; end
      issue(k, av, bv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_done(k, lat, got, pd);
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp || lat !== nk[k] || pd !== 1'b0) begin
        n_bad++;
        $display("FAIL config[%0d] a=%h b=%h: got %h lat %0d want %h lat %0d",
                 k, av, bv, got, lat, exp, nk[k]);
      end
    end
  endtask

  task automatic test_w4_exhaustive();
    int lat;
    logic [9:0] got, exp;
    logic pd;
    for (int s = 0; s < 2; s++)
      for (int ci = 0; ci < 2; ci++)
        for (int av = 0; av < 16; av++)
          for (int bv = 0; bv < 16; bv++) begin
            issue(2, 8'(av), 8'(bv), 1'(s), 1'(ci));
            wait_done(2, lat, got, pd);
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp || lat !== 4) begin
              n_bad++;
              $display("FAIL w4 s=%0d ci=%0d a=%h b=%h: got %h lat %0d want %h lat 4",
                       s, ci, av, bv, got, lat, exp);
            end
          end
  endtask

  initial begin
    rst = 1'b1;
    start_v = '0;
    sub_in = 1'b0; cin_in = 1'b0;
    a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_add_basic();
    test_vectors();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_config(1, 40);
    test_config(3, 40);
    test_w4_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
